// File: rtl/sram_dma_arbiter.sv
// Single-port SRAM front end: CPU accesses pass straight through with absolute
// priority, and a word-copy DMA engine borrows the port only in CPU-idle cycles.
module sram_dma_arbiter #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cpu_en,
   input  logic              cpu_we,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [DATA_W-1:0] cpu_di,
   output logic [DATA_W-1:0] cpu_do,
   input  logic              dma_start,
   input  logic [ADDR_W-1:0] dma_src,
   input  logic [ADDR_W-1:0] dma_dst,
   input  logic [ADDR_W-1:0] dma_len,
   output logic              dma_busy,
   output logic              dma_done,
   output logic [ADDR_W-1:0] dma_remaining,
   output logic              sram_en,
   output logic              sram_we,
   output logic [ADDR_W-1:0] sram_addr,
   output logic [DATA_W-1:0] sram_di,
   input  logic [DATA_W-1:0] sram_do
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_RD   = 3'd1;
   localparam logic [2:0] S_CAP  = 3'd2;
   localparam logic [2:0] S_WR   = 3'd3;
   localparam logic [2:0] S_DONE = 3'd4;

   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   logic [2:0]        state_q, state_d;
   logic [ADDR_W-1:0] src_q, src_d;
   logic [ADDR_W-1:0] dst_q, dst_d;
   logic [ADDR_W-1:0] remaining_q, remaining_d;
   logic [DATA_W-1:0] data_buf_q, data_buf_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              dma_rd, dma_wr;

   always_comb begin
      state_d     = state_q;
      src_d       = src_q;
      dst_d       = dst_q;
      remaining_d = remaining_q;
      data_buf_d  = data_buf_q;
      dma_rd      = 1'b0;
      dma_wr      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (dma_start) begin
               src_d       = dma_src;
               dst_d       = dma_dst;
               remaining_d = dma_len;
               state_d     = (dma_len != '0) ? S_RD : S_DONE;
            end
         end
         S_RD: begin
            if (!cpu_en) begin
               dma_rd  = 1'b1;
               state_d = S_CAP;
            end
         end
         S_CAP: begin
            // Read data is on sram_do now whoever owns the port this cycle.
            data_buf_d = sram_do;
            state_d    = S_WR;
         end
         S_WR: begin
            if (!cpu_en) begin
               dma_wr      = 1'b1;
               src_d       = src_q + ADDR_ONE;
               dst_d       = dst_q + ADDR_ONE;
               remaining_d = (remaining_q != '0) ? remaining_q - ADDR_ONE : '0;
               state_d     = (remaining_q == ADDR_ONE) ? S_DONE : S_RD;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      // Status flags are registered from the next state so they align with it.
      busy_d = (state_d == S_RD) || (state_d == S_CAP) || (state_d == S_WR);
      done_d = (state_d == S_DONE);
   end

   always_comb begin
      sram_en   = 1'b0;
      sram_we   = 1'b0;
      sram_addr = cpu_addr;
      sram_di   = cpu_di;
      if (cpu_en) begin
         sram_en = 1'b1;
         sram_we = cpu_we;
      end else if (dma_rd) begin
         sram_en   = 1'b1;
         sram_addr = src_q;
      end else if (dma_wr) begin
         sram_en   = 1'b1;
         sram_we   = 1'b1;
         sram_addr = dst_q;
         sram_di   = data_buf_q;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         src_q       <= '0;
         dst_q       <= '0;
         remaining_q <= '0;
         data_buf_q  <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         src_q       <= src_d;
         dst_q       <= dst_d;
         remaining_q <= remaining_d;
         data_buf_q  <= data_buf_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign cpu_do        = sram_do;
   assign dma_busy      = busy_q;
   assign dma_done      = done_q;
   assign dma_remaining = remaining_q;

endmodule

// File: tb/tb_sram_dma_arbiter.sv
// Scoreboard bench for sram_dma_arbiter: a reference memory predicts CPU read
// data and copy results; a slot-count model predicts DMA completion timing.
module tb_sram_dma_arbiter;
   localparam int AW = 16;
   localparam int DW = 32;
   localparam int PAT_N = 128;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          cpu_en = 1'b0, cpu_we = 1'b0;
   logic [AW-1:0] cpu_addr = '0;
   logic [DW-1:0] cpu_di = '0;
   logic [DW-1:0] cpu_do;
   logic          dma_start = 1'b0;
   logic [AW-1:0] dma_src = '0, dma_dst = '0, dma_len = '0;
   logic          dma_busy, dma_done;
   logic [AW-1:0] dma_remaining;
   logic          sram_en, sram_we;
   logic [AW-1:0] sram_addr;
   logic [DW-1:0] sram_di;
   logic [DW-1:0] sram_do;

   sram_dma_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .reset(reset),
      .cpu_en(cpu_en), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_di(cpu_di), .cpu_do(cpu_do),
      .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst), .dma_len(dma_len),
      .dma_busy(dma_busy), .dma_done(dma_done), .dma_remaining(dma_remaining),
      .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr), .sram_di(sram_di),
      .sram_do(sram_do)
   );

   always #5 clk = ~clk;

   typedef struct {int cyc; int busy;} done_exp_t;

   int            n_tests = 0;
   int            n_fail = 0;
   int            cyc = 0;
   int            busy_cnt = 0;
   int            acc_cnt = 0;
   logic          rd_issued = 1'b0;
   logic [DW-1:0] rd_q[$];
   done_exp_t     done_q[$];
   logic [AW-1:0] rem_log[$];
   logic [DW-1:0] mem [0:65535];
   logic [DW-1:0] ref_mem [0:65535];
   logic          en_pat [0:PAT_N-1];
   int            pat_mode = 0;

   function automatic logic [DW-1:0] init_val(int i);
      return (32'(i) * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Behavioural SRAM: one-cycle read latency
   initial begin
      for (int i = 0; i < 65536; i++) mem[i] = init_val(i);
      sram_do = '0;
      forever begin
         @(posedge clk);
         if (sram_en === 1'b1) begin
            if (sram_we) mem[sram_addr] <= sram_di;
            else         sram_do <= mem[sram_addr];
         end
      end
   end

   // Monitor: pops expectations whenever the DUT presents read data or done
   initial begin
      done_exp_t e;
      forever begin
         @(posedge clk);
         cyc++;
         rd_issued = (cpu_en === 1'b1) && (cpu_we === 1'b0);
         @(negedge clk);
         if (rd_issued) begin
            if (rd_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL cpu_rd: got %0h with no expected read queued", cpu_do);
            end else check("cpu_rd", cpu_do, rd_q.pop_front());
         end
         if (sram_en === 1'b1 && cpu_en === 1'b0) acc_cnt++;
         if (dma_busy === 1'b1) busy_cnt++;
         if (dma_busy === 1'b1 || dma_done === 1'b1)
            if (rem_log.size() == 0 || rem_log[$] != dma_remaining) rem_log.push_back(dma_remaining);
         if (dma_done === 1'b1) begin
            if (done_q.size() == 0) begin
               n_tests++; n_fail++;
               $display("FAIL done_pulse: got unexpected done at cycle %0d, required none", cyc);
            end else begin
               e = done_q.pop_front();
               check("done_cycle", cyc, e.cyc);
               check("busy_cycles", busy_cnt, e.busy);
               check("done_remaining", dma_remaining, 0);
               check("done_busy_low", dma_busy, 0);
            end
            busy_cnt = 0;
         end else if (dma_busy !== 1'b1) busy_cnt = 0;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   function automatic logic pat(int j);
      return (j >= 0 && j < PAT_N) ? en_pat[j] : 1'b0;
   endfunction

   task automatic clear_pat();
      for (int i = 0; i < PAT_N; i++) en_pat[i] = 1'b0;
   endtask

   task automatic readback(input logic [AW-1:0] base, input int n);
      logic [AW-1:0] a;
      for (int i = 0; i < n; i++) begin
         a = base + AW'(i);
         cpu_en = 1'b1; cpu_we = 1'b0; cpu_addr = a;
         rd_q.push_back(ref_mem[a]);
         cycle();
      end
      cpu_en = 1'b0;
      cycle();
   endtask

   // Copy of len words costs 3*len port slots; the middle slot of each word
   // never waits, the others wait out every cycle the CPU holds the port.
   task automatic do_xfer(input logic [AW-1:0] s, input logic [AW-1:0] d, input logic [AW-1:0] l,
                          input int restart_at, input int reset_at);
      int p, c, k, limit, n_copy;
      done_exp_t e;
      logic [AW-1:0] sa, da;
      p = 0; c = 0;
      while (p < 3 * int'(l)) begin
         if (p % 3 == 1 || !pat(c)) p++;
         c++;
      end
      dma_src = s; dma_dst = d; dma_len = l; dma_start = 1'b1;
      cycle();
      dma_start = 1'b0;
      k = cyc;
      n_copy = (reset_at >= 0) ? 1 : int'(l);
      for (int i = 0; i < n_copy; i++) begin
         sa = s + AW'(i);
         da = d + AW'(i);
         ref_mem[da] = ref_mem[sa];
      end
      if (reset_at < 0) begin
         e.cyc = k + c; e.busy = c;
         done_q.push_back(e);
      end
      limit = (reset_at >= 0) ? reset_at + 3 : c + 2;
      for (int j = 0; j < limit; j++) begin
         if (pat(j)) begin
            cpu_en = 1'b1;
            if (pat_mode == 0) begin
               cpu_we = 1'b0; cpu_addr = 16'h0005;
               rd_q.push_back(ref_mem[16'h0005]);
            end else begin
               cpu_addr = 16'h4000 + 16'($urandom_range(0, 255));
               cpu_we = 1'($urandom_range(0, 1));
               if (cpu_we) begin
                  cpu_di = $urandom;
                  ref_mem[cpu_addr] = cpu_di;
               end else rd_q.push_back(ref_mem[cpu_addr]);
            end
         end
         if (j == restart_at) begin
            dma_start = 1'b1; dma_src = 16'h0070; dma_dst = 16'h0080; dma_len = 16'd2;
         end
         if (j == reset_at) reset = 1'b1;
         cycle();
         cpu_en = 1'b0; cpu_we = 1'b0; dma_start = 1'b0; reset = 1'b0;
      end
      check("done_seen", done_q.size(), 0);
   endtask

   initial begin
      int r0, a0;
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
      clear_pat();
      repeat (3) cycle();
      check("rst_busy", dma_busy, 0);
      check("rst_done", dma_done, 0);
      check("rst_remaining", dma_remaining, 0);
      check("rst_sram_en", sram_en, 0);
      reset = 1'b0;
      cycle();

      // Uncontended copy of three words
      r0 = rem_log.size(); a0 = acc_cnt;
      do_xfer(16'h0010, 16'h0020, 16'd3, -1, -1);
      check("rem_steps", rem_log.size() - r0, 4);
      for (int i = 0; i < 4; i++)
         if (r0 + i < rem_log.size()) check("rem_value", rem_log[r0 + i], 3 - i);
      check("dma_accesses", acc_cnt - a0, 6);
      readback(16'h0020, 3);

      // CPU holds the port for the first four RD cycles
      for (int i = 0; i < 4; i++) en_pat[i] = 1'b1;
      do_xfer(16'h0030, 16'h0040, 16'd3, -1, -1);
      clear_pat();
      readback(16'h0040, 3);

      // Zero length
      a0 = acc_cnt;
      do_xfer(16'h0050, 16'h0058, 16'd0, -1, -1);
      check("zero_len_accesses", acc_cnt - a0, 0);

      // Restart attempt mid-transfer is ignored
      do_xfer(16'h0050, 16'h0060, 16'd4, 4, -1);
      readback(16'h0060, 4);
      readback(16'h0080, 2);

      // Address wrap
      do_xfer(16'hFFFF, 16'h0100, 16'd2, -1, -1);
      readback(16'h0100, 2);

      // Reset after the first write of a four-word copy
      do_xfer(16'h0090, 16'h00A0, 16'd4, -1, 3);
      check("abort_busy", dma_busy, 0);
      check("abort_remaining", dma_remaining, 0);
      check("abort_done", dma_done, 0);
      readback(16'h00A0, 4);
      do_xfer(16'h0090, 16'h00B0, 16'd2, -1, -1);
      readback(16'h00B0, 2);

      // Random copies with random CPU traffic in a disjoint scratch region
      pat_mode = 1;
      for (int t = 0; t < 20; t++) begin
         logic [AW-1:0] s, d, l;
         for (int i = 0; i < PAT_N; i++) en_pat[i] = ($urandom_range(0, 2) == 0);
         s = 16'h1000 + 16'($urandom_range(0, 16'h0FF0));
         d = 16'h3000 + 16'($urandom_range(0, 16'h0FF0));
         l = 16'($urandom_range(1, 6));
         do_xfer(s, d, l, -1, -1);
         readback(d, int'(l));
      end

      cycle();
      check("rd_queue_empty", rd_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/sram_dma_arbiter.md
# sram_dma_arbiter

Single-port SRAM front end between the CPU controller and the SRAM. It passes CPU accesses through with absolute priority and runs a word-copy DMA engine that uses the SRAM port only in cycles the CPU leaves idle. The CPU sees an unchanged SRAM timing. Software-visible DMA status (busy, done, remaining count) is exported for the top level.

## Interface
- ADDR_W, 16, SRAM word-address width
- DATA_W, 32, SRAM data width
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  synchronous, active-high
- cpu_en  in  1  CPU access request this cycle
- cpu_we  in  1  CPU write (valid with cpu_en)
- cpu_addr  in  ADDR_W  CPU address
- cpu_di  in  DATA_W  CPU write data
- cpu_do  out  DATA_W  read data to CPU; equals sram_do
- dma_start  in  1  start pulse, sampled only in IDLE
- dma_src  in  ADDR_W  source base, latched on accepted start
- dma_dst  in  ADDR_W  destination base, latched on accepted start
- dma_len  in  ADDR_W  word count, latched on accepted start
- dma_busy  out  1  transfer in progress (registered)
- dma_done  out  1  one-cycle completion pulse (registered)
- dma_remaining  out  ADDR_W  words not yet written (registered)
- sram_en, sram_we  out  1  SRAM enable / write enable
- sram_addr  out  ADDR_W  SRAM address
- sram_di  out  DATA_W  SRAM write data
- sram_do  in  DATA_W  SRAM read data

## Operation
- SRAM model: en/we/addr/di sampled at the rising edge ending cycle t. Read data is valid on sram_do during cycle t+1.
- Port mux (combinational): if cpu_en=1, the sram_* outputs are the cpu_* inputs. Otherwise the DMA drives them when its state issues an access. Otherwise sram_en=0, sram_we=0, and addr/di show the cpu_* values.
- cpu_do = sram_do at all times.
- DMA FSM states: IDLE, RD, CAP, WR, DONE.
  - IDLE: on dma_start, latch src_ptr, dst_ptr and remaining=dma_len. Go to RD if dma_len≠0, else go to DONE.
  - RD: if cpu_en=0, issue a read at src_ptr and go to CAP. Else stay in RD (stall).
  - CAP: buf <= sram_do, unconditionally, even if the CPU owns the port this cycle. Go to WR.
  - WR: if cpu_en=0, issue a write of buf to dst_ptr; increment src_ptr and dst_ptr; decrement remaining. Go to DONE if remaining was 1, else go to RD. If cpu_en=1, stay in WR.
  - DONE: go to IDLE.
- dma_busy=1 in RD, CAP and WR. dma_done=1 only in DONE. dma_busy=0 in DONE.
- Pointer arithmetic is modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000. remaining never underflows.
- dma_start is ignored outside IDLE, including in DONE.
- No coherence: if the CPU writes a source word after the DMA has read it, the stale value is copied. Software owns ordering.
- Reset: state=IDLE, dma_busy=0, dma_done=0, dma_remaining=0, buf=0, pointers=0. Reset during a transfer aborts it with no done pulse. Words already written stay written.

## Timing
- Start accepted at edge E0; dma_busy=1 from the cycle after E0.
- Uncontended cost is 3 cycles per word (RD, CAP, WR). N words take 3N cycles busy, plus 1 DONE cycle.
- Each cycle with cpu_en=1 while in RD or WR adds exactly one stall cycle. CAP never stalls.
- CPU latency is unchanged: a read issued in cycle t returns on cpu_do in t+1, regardless of DMA state.
- len=0: DONE is entered the cycle after the start is accepted, with zero SRAM accesses.
- dma_remaining updates on the edge that ends each WR issue cycle.

## Test plan
- Uncontended copy: mem[0x10..0x12]=A,B,C; start src=0x10 dst=0x20 len=3 -> mem[0x20..0x22]=A,B,C; busy for 9 cycles; done pulses once in the 10th cycle; remaining steps 3→2→1→0.
- CPU contention: hold cpu_en=1 (reads of 0x5) for 4 cycles while the DMA is in RD -> DMA completes exactly 4 cycles later than uncontended; the CPU gets mem[0x5] one cycle after each request; copied data is correct.
- Zero length: start with len=0 -> busy stays 0; done pulses the cycle after the start; sram_en stays 0.
- Restart ignored: a second dma_start with new src/dst mid-transfer -> the original transfer completes unchanged; the new destination region is untouched.
- Wrap: src=0xFFFF, dst=0x0100, len=2 -> copies mem[0xFFFF] and mem[0x0000] into 0x0100 and 0x0101.
- Reset mid-transfer: assert reset after the first WR of len=4 -> only dst[0] is written; busy=0, remaining=0, no done pulse; a new start then works normally.
